keypad_key_debouncer: RTL and testbench

Sits directly downstream of hex_keypad_scanner and consumes its raw code/valid pair. It qualifies each key press and release over a stable-sample window, which rejects contact bounce and scan glitches. Each qualified press emits exactly one key event into a small event FIFO with a valid/ready output handshake. It is the debounce stage that the no-debounce top-level omits; leds/led_valid are intended to be driven from key_code/key_held.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_event_fifo.sv | 56 +++++
 rtl/keypad_key_debouncer.sv | 145 ++++++++++++++
 tb/tb_keypad_key_debouncer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad widths, debouncer state type and width helper
package keypad_pkg;

  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_QUAL,
    HELD,
    RELEASE_QUAL
  } deb_state_t;

  // Bits needed to index n distinct values: ceil(log2(n)), 0 for n <= 1
  function automatic int clog2w(input int n);
    int     r;
    longint v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - generic synchronous FIFO with same-edge push/pop
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2w(DEPTH):0]  count
);

  localparam int AW = clog2w(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypad_event_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  // A pop on the same edge frees the slot, so a push while full still lands
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/keypad_key_debouncer.sv
// rtl/keypad_key_debouncer.sv - press/release qualification with key event FIFO
module keypad_key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          raw_valid,
  input  logic [KEY_CODE_W-1:0]         raw_code,
  output logic [KEY_CODE_W-1:0]         key_code,
  output logic                          key_held,
  output logic                          ev_valid,
  output logic [KEY_CODE_W-1:0]         ev_code,
  input  logic                          ev_ready,
  output logic                          overflow,
  output logic [clog2w(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = clog2w(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("keypad_key_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  deb_state_t              state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc;
  logic [KEY_CODE_W-1:0]   cand, cand_n;
  logic [KEY_CODE_W-1:0]   code_n;
  logic                    held_n;
  logic                    match;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign match    = raw_valid && (raw_code == cand);
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;

  // State, sample counter, candidate code and visible key registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_code <= '0;
      key_held <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cand     <= cand_n;
      key_code <= code_n;
      key_held <= held_n;
    end
  end

  // Qualification: a press needs DEBOUNCE_CYCLES matching samples, a release as many non-matching
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = key_code;
    held_n  = key_held;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (raw_valid) begin
          cand_n  = raw_code;
          cnt_n   = CNT_ONE;
          state_n = PRESS_QUAL;
        end
      end
      PRESS_QUAL: begin
        if (match) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_n = HELD;
            cnt_n   = '0;
            code_n  = cand;
            held_n  = 1'b1;
            push    = 1'b1;
          end
        end else if (raw_valid) begin
          cand_n = raw_code;
          cnt_n  = CNT_ONE;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      HELD: begin
        if (match) begin
          cnt_n = '0;
        end else begin
          state_n = RELEASE_QUAL;
          cnt_n   = CNT_ONE;
        end
      end
      RELEASE_QUAL: begin
        if (match) begin
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_n = IDLE;
            cnt_n   = '0;
            held_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Sticky record of a qualified press lost to a full FIFO with no pop
  always_ff @(posedge clock) begin
    if (reset) overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
  end

  keypad_event_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (cand),
    .pop       (pop),
    .head_data (ev_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_keypad_key_debouncer.sv
// tb/tb_keypad_key_debouncer.sv - scenario bench for keypad_key_debouncer
module tb_keypad_key_debouncer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       raw_valid = 1'b0;
  logic [3:0] raw_code = 4'h0;
  logic [3:0] key_code;
  logic       key_held;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_ready = 1'b0;
  logic       overflow;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  keypad_key_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_valid  (raw_valid),
    .raw_code   (raw_code),
    .key_code   (key_code),
    .key_held   (key_held),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ready   (ev_ready),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int n);
    raw_valid = 1'b1;
    raw_code  = code;
    repeat (n) tick();
  endtask

  task automatic go_low(input int n);
    raw_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    raw_valid = 1'b0;
    ev_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    logic [3:0] exp;
    int budget;
    budget = 40;
    raw_valid = 1'b0;
    ev_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      if (ev_valid) begin
        exp = exp_q.pop_front();
        checks++; if (ev_code !== exp) begin errors++; $display("FAIL %s_pop: ev_code got %0h expected %0h", name, ev_code, exp); end
      end
      tick();
      budget--;
    end
    ev_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_timeout: %0d events missing, expected 0", name, exp_q.size()); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL %s_extra: ev_valid got %0b expected 0", name, ev_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_key_code: got %0h expected 0", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_key_held: got %0b expected 0", key_held); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_ev_valid: got %0b expected 0", ev_valid); end
    checks++; if (ev_code !== 4'h0) begin errors++; $display("FAIL rst_ev_code: got %0h expected 0", ev_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_single_press();
    press(4'h5, 3);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL s1_early_held: got %0b expected 0", key_held); end
    exp_q.push_back(4'h5);
    tick();
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL s1_held: got %0b expected 1", key_held); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL s1_count: got %0d expected 1", fifo_count); end
    checks++; if (ev_valid !== 1'b1 || ev_code !== 4'h5) begin errors++; $display("FAIL s1_event: got v=%0b c=%0h expected v=1 c=5", ev_valid, ev_code); end
    repeat (6) tick();
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL s1_one_event: got %0d expected 1", fifo_count); end
    go_low(4);
    checks++; if (key_held !== 1'b0 || key_code !== 4'h5) begin errors++; $display("FAIL s1_release: got held=%0b code=%0h expected held=0 code=5", key_held, key_code); end
    drain("s1");
  endtask

  task automatic test_bounce();
    press(4'h5, 2); go_low(1); press(4'h5, 3); go_low(5);
    checks++; if (key_held !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL s2_bounce: got held=%0b count=%0d expected 0/0", key_held, fifo_count); end
    press(4'h5, 3);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL s2_early: got %0d expected 0", fifo_count); end
    exp_q.push_back(4'h5);
    tick();
    checks++; if (key_held !== 1'b1 || fifo_count !== 3'd1) begin errors++; $display("FAIL s2_qual: got held=%0b count=%0d expected 1/1", key_held, fifo_count); end
    go_low(4);
    drain("s2");
  endtask

  task automatic test_release_glitch();
    exp_q.push_back(4'hA);
    press(4'hA, 4);
    go_low(2);
    press(4'hA, 1);
    checks++; if (key_held !== 1'b1 || fifo_count !== 3'd1) begin errors++; $display("FAIL s3_glitch: got held=%0b count=%0d expected 1/1", key_held, fifo_count); end
    go_low(3);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL s3_early_release: got %0b expected 1", key_held); end
    tick();
    checks++; if (key_held !== 1'b0 || key_code !== 4'hA) begin errors++; $display("FAIL s3_release: got held=%0b code=%0h expected 0/a", key_held, key_code); end
    drain("s3");
  endtask

  task automatic test_code_change();
    press(4'h3, 2);
    press(4'h7, 3);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL s4_early: got %0d expected 0", fifo_count); end
    exp_q.push_back(4'h7);
    tick();
    checks++; if (fifo_count !== 3'd1 || key_code !== 4'h7) begin errors++; $display("FAIL s4_qual: got count=%0d code=%0h expected 1/7", fifo_count, key_code); end
    go_low(4);
    drain("s4");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int c = 1; c <= 5; c++) begin
      press(4'(c), 4);
      go_low(4);
      if (c <= 4) exp_q.push_back(4'(c));
      if (c == 4) begin
        checks++; if (overflow !== 1'b0 || fifo_count !== 3'd4) begin errors++; $display("FAIL s5_full: got ovf=%0b count=%0d expected 0/4", overflow, fifo_count); end
      end
    end
    checks++; if (overflow !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL s5_overflow: got ovf=%0b count=%0d expected 1/4", overflow, fifo_count); end
    drain("s5a");
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL s5_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      press(4'(c), 4);
      go_low(4);
      exp_q.push_back(4'(c));
    end
    press(4'h6, 3);
    exp = exp_q.pop_front();
    checks++; if (ev_code !== exp) begin errors++; $display("FAIL s5_head: got %0h expected %0h", ev_code, exp); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    exp_q.push_back(4'h6);
    checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL s5_pushpop: got count=%0d ovf=%0b expected 4/0", fifo_count, overflow); end
    go_low(4);
    drain("s5b");
  endtask

  task automatic test_reset_mid_qual();
    apply_reset();
    press(4'h8, 4); go_low(4);
    press(4'h9, 4); go_low(4);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL s6_prefill: got %0d expected 2", fifo_count); end
    press(4'hC, 2);
    reset = 1'b1;
    tick();
    checks++; if ({key_code, key_held, ev_valid, ev_code, overflow, fifo_count} !== 15'd0) begin errors++; $display("FAIL s6_reset: got code=%0h held=%0b v=%0b ev=%0h ovf=%0b count=%0d expected all 0", key_code, key_held, ev_valid, ev_code, overflow, fifo_count); end
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(4'hC);
    repeat (3) tick();
    checks++; if (fifo_count !== 3'd0 || key_held !== 1'b0) begin errors++; $display("FAIL s6_early: got count=%0d held=%0b expected 0/0", fifo_count, key_held); end
    tick();
    checks++; if (fifo_count !== 3'd1 || key_held !== 1'b1 || ev_code !== 4'hC) begin errors++; $display("FAIL s6_requal: got count=%0d held=%0b ev=%0h expected 1/1/c", fifo_count, key_held, ev_code); end
    go_low(4);
    drain("s6");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release_glitch();
    test_code_change();
    test_overflow();
    test_back_to_back();
    test_reset_mid_qual();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
